frame_buffer_scanout: RTL and testbench
=======================================

# frame_buffer_scanout

Double-buffered 1-bit frame store between `frame_renderer` and the display. It takes the renderer's pixel write stream into the back bank and scans the front bank out with a built-in video timing generator (pixel data, hsync, vsync, data-enable). At the start of vertical blanking it swaps banks, but only when the renderer reports a finished frame, and tells the renderer through a one-cycle `swap` pulse.

## Interface
- `HOR_ACTIVE_PIXELS`, 640: visible pixels per line.
- `HOR_FRONT_PORCH`, 16: clocks from end of active to hsync.
- `HOR_SYNC`, 96: hsync width in clocks.
- `HOR_BACK_PORCH`, 48: clocks from end of hsync to next active.
- `VER_ACTIVE_PIXELS`, 480: visible lines.
- `VER_FRONT_PORCH`, 10: lines from end of active to vsync.
- `VER_SYNC`, 2: vsync width in lines.
- `VER_BACK_PORCH`, 33: lines from end of vsync to next active.
- `HSYNC_POL`, 0: active level of hsync.
- `VSYNC_POL`, 0: active level of vsync.
- Derived: `WR_ADDR_WIDTH` = clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS).

Ports:
- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  renderer pixel write strobe.
- `wr_addr`  in  WR_ADDR_WIDTH  linear address, y*HOR_ACTIVE_PIXELS + x.
- `wr_data`  in  1  pixel value.
- `frame_ready`  in  1  high while the renderer has finished its frame and is waiting for `swap`.
- `swap`  out  1  one-cycle pulse; the banks have exchanged.
- `pixel`  out  1  scanned-out pixel; 0 outside active area.
- `hsync`  out  1  horizontal sync at `HSYNC_POL`.
- `vsync`  out  1  vertical sync at `VSYNC_POL`.
- `de`  out  1  high during active video.

## Operation
- Storage: two banks of HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS bits each, with one-cycle synchronous read. Contents are not reset.
- `front_sel` chooses the scanned-out bank. Writes always go to bank `!front_sel`, sampled in the same cycle as `wr_en`.
- Writes with `wr_addr` at or above H*V are dropped. Writes never touch the front bank.
- Counters:
  - `h_cnt` runs 0..H_TOTAL-1, where H_TOTAL = active + front porch + sync + back porch.
  - `v_cnt` runs 0..V_TOTAL-1 and increments when `h_cnt` wraps. Both wrap to 0.
- Active region: `h_cnt < HOR_ACTIVE_PIXELS` and `v_cnt < VER_ACTIVE_PIXELS`.
- Sync windows:
  - hsync is asserted for `h_cnt` in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC).
  - vsync is asserted for `v_cnt` in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC).
- Read address: a counter `rd_addr`, not a multiplier.
  - Cleared when `h_cnt==H_TOTAL-1` and `v_cnt==V_TOTAL-1`.
  - Incremented by 1 on every active-region cycle.
  - Otherwise holds.
- Swap point: the cycle with `h_cnt==0` and `v_cnt==VER_ACTIVE_PIXELS` (first blanking line).
  - If `frame_ready` is high in that cycle: `front_sel` toggles at the clock edge and `swap` is 1 for the next cycle.
  - Otherwise there is no swap. The same frame is shown again and the next chance is one frame later.
  - `frame_ready` outside the swap point is ignored.
- Simultaneous `wr_en` and swap in the same cycle: the write goes to the pre-toggle back bank.
- Swapping only in blanking guarantees that no visible line shows a mixture of banks.

## Timing
- Reset values:
  - `h_cnt`, `v_cnt`, `rd_addr` and `front_sel` are 0.
  - `swap`, `pixel` and `de` are 0.
  - `hsync` = `!HSYNC_POL`, `vsync` = `!VSYNC_POL`.
- The first clock after reset releases is counter state (0,0).
- Output latency: `pixel`, `de`, `hsync` and `vsync` are all registered and reflect the counter state of the previous cycle. They are mutually aligned.
- `pixel` is the front-bank bit at `rd_addr` from the previous cycle, ANDed with the delayed active flag.
- Write-to-visible: a pixel written in frame N appears no earlier than the first active line after the next successful swap.
- `swap` is high exactly 1 cycle per successful swap. It is never high on two consecutive cycles. There is at most one per frame.
- A reset asserted mid-frame aborts the frame at once:
  - counters restart at (0,0) the cycle after release;
  - `front_sel` returns to 0;
  - a pending swap is lost.

## Test plan
Benches use H=8/1/2/1 (H_TOTAL 12) and V=4/1/1/1 (V_TOTAL 7), both polarities 0.

- Reset, then run 84 cycles → `de` high for exactly 32 cycles; `hsync` low 2 cycles per line at h 9..10 (seen one cycle later); `vsync` low for all 12 cycles of line 5; `swap` never pulses with `frame_ready`=0.
- Write 1 to all 32 addresses with `frame_ready`=0 → `pixel` stays 0 for 3 full frames.
- Same writes, then hold `frame_ready`=1 → `swap` pulses once, one cycle after (h=0, v=4); the next frame has `pixel`=1 on all 32 active cycles.
- Write address 9 only to the back bank, then swap → `pixel`=1 only on line 1, x=1, and 0 in blanking.
- Pulse `frame_ready` high for one cycle at (h=0, v=3) → no swap; holding it through (0,4) → swap.
- Assert `rst` at (5,2) after a swap → the following frame reads bank 0 again; all outputs hold their reset values during `rst`.

Source files
------------

// File: rtl/frame_buffer_scanout.sv
// Double-buffered 1-bit frame store with built-in video timing.
// The renderer fills the back bank while the front bank is scanned out; banks swap at the start of vertical blanking.
module frame_buffer_scanout #(
  parameter int   HOR_ACTIVE_PIXELS = 640,
  parameter int   HOR_FRONT_PORCH   = 16,
  parameter int   HOR_SYNC          = 96,
  parameter int   HOR_BACK_PORCH    = 48,
  parameter int   VER_ACTIVE_PIXELS = 480,
  parameter int   VER_FRONT_PORCH   = 10,
  parameter int   VER_SYNC          = 2,
  parameter int   VER_BACK_PORCH    = 33,
  parameter logic HSYNC_POL         = 1'b0,
  parameter logic VSYNC_POL         = 1'b0,
  localparam int  WR_ADDR_WIDTH     = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic                     wr_data,
  input  logic                     frame_ready,
  output logic                     swap,
  output logic                     pixel,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de
);

  localparam int DEPTH   = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(HOR_ACTIVE_PIXELS);
  localparam logic [H_W-1:0] HS_START = H_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
  localparam logic [H_W-1:0] HS_END   = H_W'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(VER_ACTIVE_PIXELS);
  localparam logic [V_W-1:0] VS_START = V_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
  localparam logic [V_W-1:0] VS_END   = V_W'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC);
  localparam logic [WR_ADDR_WIDTH:0] DEPTH_X = (WR_ADDR_WIDTH + 1)'(DEPTH);

  logic bank0_mem [DEPTH];
  logic bank1_mem [DEPTH];

  logic [H_W-1:0]           h_cnt_q, h_cnt_d;
  logic [V_W-1:0]           v_cnt_q, v_cnt_d;
  logic [WR_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                     front_sel_q, front_sel_d;
  logic                     swap_q, swap_d;
  logic                     de_q, de_d;
  logic                     hsync_q, hsync_d;
  logic                     vsync_q, vsync_d;
  logic                     rd_bit_q;

  logic h_wrap, v_wrap, active, swap_now, wr_ok;

  always_comb begin
    h_wrap   = (h_cnt_q == H_LAST);
    v_wrap   = (v_cnt_q == V_LAST);
    active   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    swap_now = (h_cnt_q == '0) && (v_cnt_q == V_ACT) && frame_ready;
    wr_ok    = wr_en && ({1'b0, wr_addr} < DEPTH_X);

    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
    end

    // Linear scan address follows the active region; no y*width product needed.
    rd_addr_d = rd_addr_q;
    if (h_wrap && v_wrap) begin
      rd_addr_d = '0;
    end else if (active) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end

    front_sel_d = front_sel_q ^ swap_now;
    swap_d      = swap_now;
    de_d        = active;
    hsync_d     = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d     = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      rd_addr_q   <= '0;
      front_sel_q <= 1'b0;
      swap_q      <= 1'b0;
      de_q        <= 1'b0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      rd_addr_q   <= rd_addr_d;
      front_sel_q <= front_sel_d;
      swap_q      <= swap_d;
      de_q        <= de_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  // Writes use the pre-toggle bank select, so a write coinciding with a swap lands in the old back bank.
  always_ff @(posedge clk) begin
    if (wr_ok && front_sel_q) begin
      bank0_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !front_sel_q) begin
      bank1_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_bit_q <= front_sel_q ? bank1_mem[rd_addr_q] : bank0_mem[rd_addr_q];
  end

  assign pixel = rd_bit_q & de_q;
  assign swap  = swap_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Directed bench for frame_buffer_scanout with a 12x7 timing grid (8x4 active).
module tb_frame_buffer_scanout;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic       wr_data = 1'b0;
  logic       frame_ready = 1'b0;
  logic       swap, pixel, hsync, vsync, de;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int de_cnt = 0;

  frame_buffer_scanout #(
    .HOR_ACTIVE_PIXELS(8), .HOR_FRONT_PORCH(1), .HOR_SYNC(2), .HOR_BACK_PORCH(1),
    .VER_ACTIVE_PIXELS(4), .VER_FRONT_PORCH(1), .VER_SYNC(1), .VER_BACK_PORCH(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ready(frame_ready), .swap(swap), .pixel(pixel), .hsync(hsync),
    .vsync(vsync), .de(de)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (frame cycle %0d)", tag, obs, exp_v, k);
    end
  endtask

  task automatic rst_chk();
    chk("rst_de", de, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_swap", swap, 0);
    chk("rst_pixel", pixel, 0);
  endtask

  // One clock with the given inputs; checks outputs that reflect frame cycle k.
  // pmode: -1 skip pixel, 0 all dark, 1 all lit, 2 only addresses 2 and 9 lit.
  task automatic cyc(input logic we, input int a, input logic d, input logic fr,
                     input int pmode, input logic exp_swap);
    int h, v, lin;
    logic act, exp_p;
    wr_en = we;
    wr_addr = 5'(a);
    wr_data = d;
    frame_ready = fr;
    @(posedge clk);
    #1;
    h = k % 12;
    v = k / 12;
    lin = v * 8 + h;
    act = (h < 8) && (v < 4);
    chk("de", de, int'(act));
    chk("hsync", hsync, int'(!(h == 9 || h == 10)));
    chk("vsync", vsync, int'(v != 5));
    chk("swap", swap, int'(exp_swap));
    if (pmode >= 0) begin
      exp_p = act && ((pmode == 1) || (pmode == 2 && (lin == 2 || lin == 9)));
      chk("pixel", pixel, int'(exp_p));
    end
    if (de) de_cnt++;
    k = (k + 1) % 84;
  endtask

  initial begin
    // Reset values while rst is held
    repeat (3) begin
      @(posedge clk);
      #1;
      rst_chk();
    end
    rst = 1'b0;
    k = 0;

    // Frame A: no frame_ready, clear bank 1 with zeros, full timing checks
    de_cnt = 0;
    for (int i = 0; i < 84; i++) cyc(i < 32, i, 1'b0, 1'b0, -1, 1'b0);
    chk("de_count", de_cnt, 32);

    // Frame B: swap to bank 1, then clear bank 0 during blanking
    for (int i = 0; i < 84; i++) cyc(i >= 50 && i < 82, i - 50, 1'b0, 1'b1, -1, i == 48);

    // Frames C-E: ones written to back bank stay invisible without a swap
    for (int i = 0; i < 84; i++) cyc(i < 32, i, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 168; i++) cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Frame F: frame_ready held, single swap one cycle after (0,4)
    for (int i = 0; i < 84; i++) cyc(1'b0, 0, 1'b0, 1'b1, 0, i == 48);

    // Frame G: all ones visible; write addr 9 to back; short frame_ready at (0,3) is ignored
    for (int i = 0; i < 84; i++) cyc(i == 0, 9, 1'b1, i == 36, 1, 1'b0);

    // Frame H: frame_ready from (0,3) through (0,4) swaps; write at swap cycle hits old back bank
    for (int i = 0; i < 84; i++) cyc(i == 48, 2, 1'b1, i >= 36 && i <= 48, 1, i == 48);

    // Frame I: bank 1 shows only addresses 2 and 9; reset hits at (5,2)
    for (int i = 0; i < 29; i++) cyc(1'b0, 0, 1'b0, 1'b0, 2, 1'b0);
    wr_en = 1'b0;
    frame_ready = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      rst_chk();
    end
    rst = 1'b0;
    k = 0;

    // Frame K: front select back to bank 0 (all ones), counters from (0,0)
    de_cnt = 0;
    for (int i = 0; i < 84; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1, 1'b0);
    chk("de_count_after_rst", de_cnt, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
